// File: rtl/pipe_buffer.sv
// pipe_buffer: DEPTH collapsing register stages with stall hold, flush squash and an occupancy count.
// Define PIPE_BUFFER_SKID_EN to add a skid entry after the last stage and register in_ready.
module pipe_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              stall,
  input  logic              flush,
  output logic [4:0]        occupancy
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [4:0]        occ_q, occ_d;
  logic [DEPTH-1:0]  room;
  logic              lastRoom, roomAcc, accept, consume, outAvail;
  logic [DATA_W-1:0] headData;

`ifdef PIPE_BUFFER_SKID_EN
  logic              skidValid_q, skidValid_d;
  logic [DATA_W-1:0] skidData_q, skidData_d;
  logic              inReady_q;

  // The skid entry, when occupied, holds the oldest word and is presented first.
  assign outAvail = skidValid_q | valid_q[DEPTH-1];
  assign headData = skidValid_q ? skidData_q : data_q[DEPTH-1];
  assign lastRoom = !valid_q[DEPTH-1] | !skidValid_q | out_ready;
  assign in_ready = inReady_q & !stall & !flush & !rst;
`else
  assign outAvail = valid_q[DEPTH-1];
  assign headData = data_q[DEPTH-1];
  assign lastRoom = !valid_q[DEPTH-1] | out_ready;
  assign in_ready = room[0] & !stall & !flush & !rst;
`endif

  assign out_valid = outAvail & !stall & !rst;
  assign out_data  = rst ? '0 : headData;
  assign occupancy = occ_q;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  // A stage can load when it or any stage downstream of it has a hole, or the tail drains.
  always_comb begin
    room    = '0;
    roomAcc = lastRoom;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      roomAcc = roomAcc | !valid_q[i];
      room[i] = roomAcc;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    occ_d   = occ_q;
    if (flush) begin
      valid_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = '0;
      end
      occ_d = '0;
    end else if (!stall) begin
      if (room[0]) begin
        valid_d[0] = accept;
        if (accept) begin
          data_d[0] = in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (room[i]) begin
          valid_d[i] = valid_q[i-1];
          if (valid_q[i-1]) begin
            data_d[i] = data_q[i-1];
          end
        end
      end
      occ_d = occ_q + {4'd0, accept} - {4'd0, consume};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      occ_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

`ifdef PIPE_BUFFER_SKID_EN
  // The tail word drops into the skid entry whenever the consumer is not taking it.
  always_comb begin
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    if (flush) begin
      skidValid_d = 1'b0;
      skidData_d  = '0;
    end else if (!stall) begin
      if (skidValid_q) begin
        if (out_ready) begin
          skidValid_d = valid_q[DEPTH-1];
          if (valid_q[DEPTH-1]) begin
            skidData_d = data_q[DEPTH-1];
          end
        end
      end else if (valid_q[DEPTH-1] && !out_ready) begin
        skidValid_d = 1'b1;
        skidData_d  = data_q[DEPTH-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
      inReady_q   <= 1'b0;
    end else begin
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
      inReady_q   <= !skidValid_d & !stall & !flush;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_buffer.sv
// Self-checking bench for pipe_buffer: directed scenarios plus randomized traffic against a queue model.
// With PIPE_BUFFER_SKID_EN defined only the skid overflow scenario is exercised (DEPTH=2).
module tb_pipe_buffer;

`ifdef PIPE_BUFFER_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 3;
`endif
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              stall;
  logic              flush;
  logic [4:0]        occupancy;

  int vectors = 0;
  int miscompares = 0;

  pipe_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .stall(stall), .flush(flush), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setInputs(input bit iv, input logic [DATA_W-1:0] d, input bit ordy,
                           input bit st, input bit fl, input bit rs);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    rst       = rs;
  endtask

  task automatic applyStimulus(input bit iv, input logic [DATA_W-1:0] d, input bit ordy,
                               input bit st, input bit fl, input bit rs);
    setInputs(iv, d, ordy, st, fl, rs);
    @(posedge clk);
    #1;
  endtask

`ifndef PIPE_BUFFER_SKID_EN
  // Model: queue of stored words, oldest first, each with how far down the pipe it has travelled.
  logic [DATA_W-1:0] mData[$];
  int                mPos[$];
  bit                mAcc, mCon;
  int                mLim, mNew;

  function automatic bit headAtOut();
    return (mData.size() > 0) && (mPos[0] == DEPTH - 1);
  endfunction

  function automatic bit expInReady();
    return !rst && !stall && !flush && ((mData.size() < DEPTH) || out_ready);
  endfunction

  function automatic bit expOutValid();
    return !rst && !stall && headAtOut();
  endfunction

  always @(posedge clk) begin
    if (rst || flush) begin
      mData.delete();
      mPos.delete();
    end else if (!stall) begin
      mAcc = in_valid && ((mData.size() < DEPTH) || out_ready);
      mCon = headAtOut() && out_ready;
      if (mCon) begin
        void'(mData.pop_front());
        void'(mPos.pop_front());
      end
      mLim = DEPTH - 1;
      foreach (mPos[j]) begin
        mNew    = (mPos[j] + 1 < mLim) ? mPos[j] + 1 : mLim;
        mPos[j] = mNew;
        mLim    = mNew - 1;
      end
      if (mAcc) begin
        mData.push_back(in_data);
        mPos.push_back(0);
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("in_ready", 32'(in_ready), 32'(expInReady()));
    checkOutput("out_valid", 32'(out_valid), 32'(expOutValid()));
    checkOutput("occupancy", 32'(occupancy), 32'(mData.size()));
    if (rst) begin
      checkOutput("out_data_in_reset", 32'(out_data), 32'd0);
    end else if (headAtOut()) begin
      checkOutput("out_data", 32'(out_data), 32'(mData[0]));
    end
  end
`endif

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    setInputs(0, 8'h00, 0, 0, 0, 1);
    applyStimulus(0, 8'h00, 0, 0, 0, 1);
    applyStimulus(0, 8'h00, 0, 0, 0, 1);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("reset_occupancy", 32'(occupancy), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

`ifdef PIPE_BUFFER_SKID_EN
    applyStimulus(1, 8'hA1, 1, 0, 0, 0);
    applyStimulus(1, 8'hA2, 1, 0, 0, 0);
    checkOutput("skid_first_out", 32'(out_data), 32'hA1);
    checkOutput("skid_first_valid", 32'(out_valid), 32'd1);
    applyStimulus(1, 8'hA3, 1, 0, 0, 0);
    checkOutput("skid_stream_out", 32'(out_data), 32'hA2);
    checkOutput("skid_stream_occ", 32'(occupancy), 32'd2);
    setInputs(1, 8'hA4, 0, 0, 0, 0);
    #1;
    checkOutput("skid_ready_before_drop", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("skid_overflow_occ", 32'(occupancy), 32'd3);
    checkOutput("skid_overflow_ready", 32'(in_ready), 32'd0);
    checkOutput("skid_overflow_out", 32'(out_data), 32'hA2);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("skid_drain_a3", 32'(out_data), 32'hA3);
    checkOutput("skid_drain_occ2", 32'(occupancy), 32'd2);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("skid_drain_a4", 32'(out_data), 32'hA4);
    checkOutput("skid_drain_occ1", 32'(occupancy), 32'd1);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("skid_empty_occ", 32'(occupancy), 32'd0);
    checkOutput("skid_empty_valid", 32'(out_valid), 32'd0);
`else
    // Streaming with the consumer always ready.
    applyStimulus(1, 8'h11, 1, 0, 0, 0);
    checkOutput("stream_lat1_valid", 32'(out_valid), 32'd0);
    applyStimulus(1, 8'h22, 1, 0, 0, 0);
    checkOutput("stream_lat2_valid", 32'(out_valid), 32'd0);
    applyStimulus(1, 8'h33, 1, 0, 0, 0);
    checkOutput("stream_first_valid", 32'(out_valid), 32'd1);
    checkOutput("stream_first_data", 32'(out_data), 32'h11);
    checkOutput("stream_occ", 32'(occupancy), 32'd3);
    checkOutput("model_stream_occ", 32'(mData.size()), 32'd3);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("stream_second", 32'(out_data), 32'h22);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("stream_third", 32'(out_data), 32'h33);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("stream_drained", 32'(occupancy), 32'd0);

    // Backpressure: four words offered, three fit.
    applyStimulus(1, 8'h11, 0, 0, 0, 0);
    applyStimulus(1, 8'h22, 0, 0, 0, 0);
    applyStimulus(1, 8'h33, 0, 0, 0, 0);
    setInputs(1, 8'h44, 0, 0, 0, 0);
    #1;
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_occ", 32'(occupancy), 32'd3);
    applyStimulus(1, 8'h44, 0, 0, 0, 0);
    checkOutput("bp_occ_held", 32'(occupancy), 32'd3);
    checkOutput("bp_head", 32'(out_data), 32'h11);
    setInputs(1, 8'h44, 1, 0, 0, 0);
    #1;
    checkOutput("bp_ready_on_drain", 32'(in_ready), 32'd1);
    applyStimulus(1, 8'h44, 1, 0, 0, 0);
    checkOutput("bp_out_22", 32'(out_data), 32'h22);
    checkOutput("bp_full_thru", 32'(occupancy), 32'd3);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("bp_out_33", 32'(out_data), 32'h33);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("bp_out_44", 32'(out_data), 32'h44);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);

    // Stall with two words held.
    applyStimulus(1, 8'h55, 0, 0, 0, 0);
    applyStimulus(1, 8'h66, 0, 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1, 8'h77, 1, 1, 0, 0);
      checkOutput("stall_out_valid", 32'(out_valid), 32'd0);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_occ", 32'(occupancy), 32'd2);
      checkOutput("stall_data", 32'(out_data), 32'h55);
    end
    setInputs(0, 8'h00, 1, 0, 0, 0);
    #1;
    checkOutput("stall_release_55", 32'(out_data), 32'h55);
    checkOutput("stall_release_valid", 32'(out_valid), 32'd1);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("stall_release_66", 32'(out_data), 32'h66);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);

    // Flush beats stall and the offered word.
    applyStimulus(1, 8'h81, 0, 0, 0, 0);
    applyStimulus(1, 8'h82, 0, 0, 0, 0);
    applyStimulus(1, 8'h83, 0, 0, 0, 0);
    applyStimulus(1, 8'h99, 1, 1, 1, 0);
    setInputs(0, 8'h00, 0, 0, 0, 0);
    #1;
    checkOutput("flush_occ", 32'(occupancy), 32'd0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_out_data", 32'(out_data), 32'd0);
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    checkOutput("flush_nothing_stored", 32'(occupancy), 32'd0);

    // Reset while full and the consumer ready.
    applyStimulus(1, 8'hA1, 0, 0, 0, 0);
    applyStimulus(1, 8'hA2, 0, 0, 0, 0);
    applyStimulus(1, 8'hA3, 0, 0, 0, 0);
    setInputs(1, 8'hA4, 1, 0, 0, 1);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1, 8'hA4, 1, 0, 0, 1);
    setInputs(0, 8'h00, 1, 0, 0, 0);
    #1;
    checkOutput("rst_after_occ", 32'(occupancy), 32'd0);
    checkOutput("rst_after_valid", 32'(out_valid), 32'd0);
    applyStimulus(1, 8'hAB, 1, 0, 0, 0);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("rst_ab_not_yet", 32'(out_valid), 32'd0);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("rst_ab_valid", 32'(out_valid), 32'd1);
    checkOutput("rst_ab_data", 32'(out_data), 32'hAB);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);

    // Randomized traffic in three phases of differing pressure.
    for (int n = 0; n < 3000; n++) begin
      int ivPct, orPct;
      ivPct = (n < 1000) ? 80 : (n < 2000) ? 90 : 50;
      orPct = (n < 1000) ? 90 : (n < 2000) ? 30 : 60;
      applyStimulus($urandom_range(0, 99) < ivPct, 8'($urandom), $urandom_range(0, 99) < orPct,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 199) == 0);
    end
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
